mem_port_arbiter: RTL and testbench

//   Shares the CPU's single memory port between instruction fetch (IF) and load/store (data, D).

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the fetch and load/store requesters, the arbiter and memory.
// The arbiter uses the slave view; the surrounding environment uses the master view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  if_req_valid;
    logic                  if_req_ready;
    logic [ADDR_W-1:0]     if_req_addr;
    logic                  if_rsp_valid;
    logic [DATA_W-1:0]     if_rsp_rdata;

    logic                  d_req_valid;
    logic                  d_req_ready;
    logic [ADDR_W-1:0]     d_req_addr;
    logic                  d_req_we;
    logic [DATA_W-1:0]     d_req_wdata;
    logic [DATA_W/8-1:0]   d_req_wstrb;
    logic                  d_rsp_valid;
    logic [DATA_W-1:0]     d_rsp_rdata;

    logic                  m_req_valid;
    logic                  m_req_ready;
    logic [ADDR_W-1:0]     m_req_addr;
    logic                  m_req_we;
    logic [DATA_W-1:0]     m_req_wdata;
    logic [DATA_W/8-1:0]   m_req_wstrb;
    logic                  m_rsp_valid;
    logic [DATA_W-1:0]     m_rsp_rdata;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_rsp_valid, if_rsp_rdata,
        input  d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
        output d_req_ready, d_rsp_valid, d_rsp_rdata,
        output m_req_valid, m_req_addr, m_req_we, m_req_wdata, m_req_wstrb,
        input  m_req_ready, m_rsp_valid, m_rsp_rdata
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_rdata,
        output d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
        input  d_req_ready, d_rsp_valid, d_rsp_rdata,
        input  m_req_valid, m_req_addr, m_req_we, m_req_wdata, m_req_wstrb,
        output m_req_ready, m_rsp_valid, m_rsp_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction in flight.
// Optional WAIT-state timeout with sticky timeout_err: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned STARVE_MAX  = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus,
`ifdef MEM_ARB_TIMEOUT_EN
    output logic               timeout_err,
`endif
    output logic               busy
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic                owner_q, owner_d;  // 1: load/store owns the transaction
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                if_rsp_valid_q, if_rsp_valid_d;
    logic [DATA_W-1:0]   if_rsp_rdata_q, if_rsp_rdata_d;
    logic                d_rsp_valid_q, d_rsp_valid_d;
    logic [DATA_W-1:0]   d_rsp_rdata_q, d_rsp_rdata_d;
    logic                if_ready, d_ready;
    logic                rsp_fire;
    logic [DATA_W-1:0]   rsp_data;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic                timeout_q, timeout_d;
`else
    logic                unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

    always_comb begin
        state_d        = state_q;
        starve_cnt_d   = starve_cnt_q;
        owner_d        = owner_q;
        addr_d         = addr_q;
        we_d           = we_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        if_rsp_valid_d = 1'b0;
        if_rsp_rdata_d = if_rsp_rdata_q;
        d_rsp_valid_d  = 1'b0;
        d_rsp_rdata_d  = d_rsp_rdata_q;
        if_ready       = 1'b0;
        d_ready        = 1'b0;
        rsp_fire       = 1'b0;
        rsp_data       = bus.m_rsp_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
        wait_cnt_d     = '0;
        timeout_d      = timeout_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.if_req_valid &&
                    (!bus.d_req_valid || starve_cnt_q == CNT_W'(STARVE_MAX))) begin
                    if_ready     = 1'b1;
                    owner_d      = 1'b0;
                    addr_d       = bus.if_req_addr;
                    we_d         = 1'b0;
                    wdata_d      = '0;
                    wstrb_d      = '0;
                    starve_cnt_d = '0;
                    state_d      = StIssue;
                end else if (bus.d_req_valid) begin
                    d_ready = 1'b1;
                    owner_d = 1'b1;
                    addr_d  = bus.d_req_addr;
                    we_d    = bus.d_req_we;
                    wdata_d = bus.d_req_wdata;
                    wstrb_d = bus.d_req_wstrb;
                    if (bus.if_req_valid && starve_cnt_q != CNT_W'(STARVE_MAX)) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (bus.m_req_ready) state_d = StWait;
            end
            StWait: begin
                if (bus.m_rsp_valid) begin
                    rsp_fire = 1'b1;
                    state_d  = StIdle;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wait_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    rsp_fire  = 1'b1;
                    rsp_data  = '1;
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase

        if (rsp_fire) begin
            if (owner_q) begin
                d_rsp_valid_d = 1'b1;
                d_rsp_rdata_d = rsp_data;
            end else begin
                if_rsp_valid_d = 1'b1;
                if_rsp_rdata_d = rsp_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            starve_cnt_q   <= '0;
            owner_q        <= 1'b0;
            addr_q         <= '0;
            we_q           <= 1'b0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            if_rsp_valid_q <= 1'b0;
            if_rsp_rdata_q <= '0;
            d_rsp_valid_q  <= 1'b0;
            d_rsp_rdata_q  <= '0;
        end else begin
            state_q        <= state_d;
            starve_cnt_q   <= starve_cnt_d;
            owner_q        <= owner_d;
            addr_q         <= addr_d;
            we_q           <= we_d;
            wdata_q        <= wdata_d;
            wstrb_q        <= wstrb_d;
            if_rsp_valid_q <= if_rsp_valid_d;
            if_rsp_rdata_q <= if_rsp_rdata_d;
            d_rsp_valid_q  <= d_rsp_valid_d;
            d_rsp_rdata_q  <= d_rsp_rdata_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end
    assign timeout_err = timeout_q;
`endif

    assign bus.if_req_ready = if_ready;
    assign bus.d_req_ready  = d_ready;
    assign bus.if_rsp_valid = if_rsp_valid_q;
    assign bus.if_rsp_rdata = if_rsp_rdata_q;
    assign bus.d_rsp_valid  = d_rsp_valid_q;
    assign bus.d_rsp_rdata  = d_rsp_rdata_q;
    assign bus.m_req_valid  = (state_q == StIssue);
    assign bus.m_req_addr   = addr_q;
    assign bus.m_req_we     = we_q;
    assign bus.m_req_wdata  = wdata_q;
    assign bus.m_req_wstrb  = wstrb_q;
    assign busy             = (state_q != StIdle);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected memory requests and routed responses are queued
// by the stimulus and popped by independent memory-model and response-monitor processes.
module tb_mem_port_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
`ifdef MEM_ARB_TIMEOUT_EN
    logic timeout_err;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .STARVE_MAX  (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
`ifdef MEM_ARB_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .busy        (busy)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } rsp_t;

    req_t exp_req[$];
    rsp_t exp_rsp[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rsp_cyc = 0;

    int stall_left = 0;
    bit mem_silent = 1'b0;
    bit inject = 1'b0;
    bit rsp_pending = 1'b0;
    logic [31:0] rsp_data_q = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: optional request stall, zero-wait response unless silenced.
    initial begin
        bus.m_req_ready = 1'b0;
        bus.m_rsp_valid = 1'b0;
        bus.m_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            bus.m_rsp_valid = 1'b0;
            bus.m_req_ready = 1'b0;
            if (!rst_n) begin
                rsp_pending = 1'b0;
            end else begin
                if (rsp_pending) begin
                    bus.m_rsp_valid = 1'b1;
                    bus.m_rsp_rdata = rsp_data_q;
                    rsp_pending = 1'b0;
                end
                if (inject) begin
                    bus.m_rsp_valid = 1'b1;
                    bus.m_rsp_rdata = 32'hDEAD_BEEF;
                    inject = 1'b0;
                end
                if (bus.m_req_valid) begin
                    chk("m_req_expected", exp_req.size() > 0, 1);
                    if (exp_req.size() > 0) begin
                        chk("m_req_addr", bus.m_req_addr, exp_req[0].addr);
                        chk("m_req_we", bus.m_req_we, exp_req[0].we);
                        chk("m_req_wdata", bus.m_req_wdata, exp_req[0].wdata);
                        chk("m_req_wstrb", bus.m_req_wstrb, exp_req[0].wstrb);
                    end
                    if (stall_left > 0) begin
                        stall_left--;
                    end else begin
                        bus.m_req_ready = 1'b1;
                        if (exp_req.size() > 0) void'(exp_req.pop_front());
                        if (!mem_silent) begin
                            rsp_pending = 1'b1;
                            rsp_data_q  = mem_data(bus.m_req_addr);
                        end
                    end
                end
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) chk("ready_while_busy", {bus.if_req_ready, bus.d_req_ready}, 0);
            if (bus.if_rsp_valid || bus.d_rsp_valid) begin
                chk("rsp_onehot", bus.if_rsp_valid & bus.d_rsp_valid, 0);
                chk("rsp_expected", exp_rsp.size() > 0, 1);
                if (exp_rsp.size() > 0) begin
                    rsp_t e;
                    e = exp_rsp.pop_front();
                    chk("rsp_port_is_d", bus.d_rsp_valid, e.is_d);
                    chk("rsp_rdata", e.is_d ? bus.d_rsp_rdata : bus.if_rsp_rdata, e.data);
                    last_rsp_cyc = cyc;
                end
            end
        end
    end

    task automatic if_req(input logic [31:0] a, output int hs);
        int n = 0;
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = a;
        #1;
        while (!bus.if_req_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("if_req_accept_bound", n < 100, 1);
        hs = cyc;
        @(negedge clk);
        bus.if_req_valid = 1'b0;
    endtask

    task automatic d_req(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         input logic [3:0] ws, output int hs);
        int n = 0;
        bus.d_req_valid = 1'b1;
        bus.d_req_addr  = a;
        bus.d_req_we    = we;
        bus.d_req_wdata = wd;
        bus.d_req_wstrb = ws;
        #1;
        while (!bus.d_req_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("d_req_accept_bound", n < 100, 1);
        hs = cyc;
        @(negedge clk);
        bus.d_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_rsp.size() != 0 || exp_req.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_bound", n < 200, 1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_if_req_ready"}, bus.if_req_ready, 0);
        chk({tag, "_d_req_ready"}, bus.d_req_ready, 0);
        chk({tag, "_if_rsp_valid"}, bus.if_rsp_valid, 0);
        chk({tag, "_if_rsp_rdata"}, bus.if_rsp_rdata, 0);
        chk({tag, "_d_rsp_valid"}, bus.d_rsp_valid, 0);
        chk({tag, "_d_rsp_rdata"}, bus.d_rsp_rdata, 0);
        chk({tag, "_m_req_valid"}, bus.m_req_valid, 0);
        chk({tag, "_m_req_addr"}, bus.m_req_addr, 0);
        chk({tag, "_m_req_we"}, bus.m_req_we, 0);
        chk({tag, "_m_req_wdata"}, bus.m_req_wdata, 0);
        chk({tag, "_m_req_wstrb"}, bus.m_req_wstrb, 0);
        chk({tag, "_busy"}, busy, 0);
`ifdef MEM_ARB_TIMEOUT_EN
        chk({tag, "_timeout_err"}, timeout_err, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, hs_d, hs_i;
        bus.if_req_valid = 1'b0;
        bus.if_req_addr  = '0;
        bus.d_req_valid  = 1'b0;
        bus.d_req_addr   = '0;
        bus.d_req_we     = 1'b0;
        bus.d_req_wdata  = '0;
        bus.d_req_wstrb  = '0;

        repeat (2) @(negedge clk);
        #1;
        check_reset("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: fetch only, minimum latency
        exp_req.push_back('{addr: 32'h100, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
        exp_rsp.push_back('{is_d: 1'b0, data: 32'h0000_0013});
        if_req(32'h100, hs);
        wait_idle();
        chk("t1_latency", last_rsp_cyc - hs, 3);

        // 2: contention, D wins, IF granted the cycle D returns to idle
        exp_req.push_back('{addr: 32'h8000, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
        exp_req.push_back('{addr: 32'h200, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
        exp_rsp.push_back('{is_d: 1'b1, data: 32'h5A5A_8000});
        exp_rsp.push_back('{is_d: 1'b0, data: 32'h5A5A_0200});
        fork
            d_req(32'h8000, 1'b0, 32'h0, 4'h0, hs_d);
            if_req(32'h200, hs_i);
        join
        wait_idle();
        chk("t2_if_grant_gap", hs_i - hs_d, 3);

        // 3: starvation guard: four D grants, then IF, then the remaining D
        for (int i = 0; i < 4; i++) begin
            exp_req.push_back('{addr: 32'h1000 + 32'(4 * i), we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
            exp_rsp.push_back('{is_d: 1'b1, data: (32'h1000 + 32'(4 * i)) ^ 32'h5A5A_0000});
        end
        exp_req.push_back('{addr: 32'h300, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
        exp_rsp.push_back('{is_d: 1'b0, data: 32'h5A5A_0300});
        exp_req.push_back('{addr: 32'h1010, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
        exp_rsp.push_back('{is_d: 1'b1, data: 32'h5A5A_1010});
        fork
            begin
                for (int i = 0; i < 5; i++) d_req(32'h1000 + 32'(4 * i), 1'b0, 32'h0, 4'h0, hs_d);
            end
            if_req(32'h300, hs_i);
        join
        wait_idle();
        chk("t3_starve_cnt_cleared", dut.starve_cnt_q, 0);

        // 4: write with request backpressure; IF arrives while D is outstanding
        stall_left = 3;
        exp_req.push_back('{addr: 32'h40, we: 1'b1, wdata: 32'hA5A5_A5A5, wstrb: 4'hF});
        exp_req.push_back('{addr: 32'h180, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
        exp_rsp.push_back('{is_d: 1'b1, data: 32'h5A5A_0040});
        exp_rsp.push_back('{is_d: 1'b0, data: 32'h5A5A_0180});
        fork
            d_req(32'h40, 1'b1, 32'hA5A5_A5A5, 4'hF, hs_d);
            begin
                @(negedge clk);
                if_req(32'h180, hs_i);
            end
        join
        wait_idle();
        chk("t4_d_then_if_gap", hs_i - hs_d, 6);

        // 5: reset while waiting for memory, then a late response
        mem_silent = 1'b1;
        exp_req.push_back('{addr: 32'h500, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
        d_req(32'h500, 1'b0, 32'h0, 4'h0, hs_d);
        repeat (2) @(negedge clk);
        chk("t5_busy_in_wait", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset("t5_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mem_silent = 1'b0;
        inject = 1'b1;
        repeat (4) @(negedge clk);
        check_reset("t5_after");

`ifdef MEM_ARB_TIMEOUT_EN
        // 6: memory never answers; timeout response after 8 WAIT cycles
        mem_silent = 1'b1;
        exp_req.push_back('{addr: 32'h600, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
        exp_rsp.push_back('{is_d: 1'b1, data: 32'hFFFF_FFFF});
        d_req(32'h600, 1'b0, 32'h0, 4'h0, hs_d);
        wait_idle();
        chk("t6_latency", last_rsp_cyc - hs_d, 10);
        chk("t6_timeout_err", timeout_err, 1);
        chk("t6_busy", busy, 0);
        mem_silent = 1'b0;
        inject = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_stray_busy", busy, 0);
        chk("t6_sticky", timeout_err, 1);
`endif

        chk("end_req_queue_empty", exp_req.size(), 0);
        chk("end_rsp_queue_empty", exp_rsp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
